// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 voting at ticks 7/8/9
module uart_rx_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMPLE_AT = 4'd8;
`else
  localparam logic [3:0] SAMPLE_AT = 4'd7;
`endif
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [DW-1:0]        div_q, div_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rxs, tick, sample, bit_v, accept;
  assign rxs = sync_q[1];
  assign tick = div_q == DW'(DIV - 1);
  assign sample = tick && tcnt_q == SAMPLE_AT;
  assign accept = done_q && (!rx_valid_q || rx_ready);
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] m_q, m_d;
  assign bit_v = (m_q[0] & m_q[1]) | (rxs & (m_q[0] | m_q[1]));
`else
  assign bit_v = rxs;
`endif
  always_comb begin
    sync_d = {sync_q[0], rx};
    prev_d = rxs;
    state_d = state_q;
    div_d = tick ? '0 : div_q + 1'b1;
    tcnt_d = tick ? tcnt_q + 4'd1 : tcnt_q;
    bcnt_d = bcnt_q;
    sh_d = sh_q;
    par_d = par_q;
    pe_d = pe_q;
    fe_d = fe_q;
    done_d = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    m_d = m_q;
    if (tick && tcnt_q == 4'd6) m_d[0] = rxs;
    if (tick && tcnt_q == 4'd7) m_d[1] = rxs;
`endif
    case (state_q)
      S_IDLE: if (prev_q && !rxs) begin
        state_d = S_START;
        div_d = '0;
        tcnt_d = '0;
        bcnt_d = '0;
        par_d = 1'b0;
        pe_d = 1'b0;
        fe_d = 1'b0;
      end
      S_START: if (sample) state_d = bit_v ? S_IDLE : S_DATA;
      S_DATA: if (sample) begin
        sh_d = {bit_v, sh_q[DATA_BITS-1:1]};
        par_d = par_q ^ bit_v;
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q == 4'(DATA_BITS - 1)) begin
          bcnt_d = '0;
          state_d = PARITY != 0 ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (sample) begin
        pe_d = PARITY == 1 ? ~(par_q ^ bit_v) : par_q ^ bit_v;
        state_d = S_STOP;
      end
      S_STOP: if (sample) begin
        fe_d = fe_q | ~bit_v;
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q == 4'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_data_d = accept ? sh_q : rx_data_q;
    frame_err_d = accept ? fe_q : frame_err_q;
    parity_err_d = accept ? pe_q : parity_err_q;
    rx_valid_d = accept | (rx_valid_q & ~rx_ready);
    overrun_d = (done_q & rx_valid_q & ~rx_ready) | (overrun_q & ~(rx_valid_q & rx_ready));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      div_q <= '0;
      tcnt_q <= '0;
      bcnt_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      done_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      m_q <= 2'b11;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      div_q <= div_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
      sh_q <= sh_d;
      par_q <= par_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      done_q <= done_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
      m_q <= m_d;
`endif
    end
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun = overrun_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives 8N1 and 7E1 receivers with table, random and corner-case frames
module tb_uart_rx_core;
  localparam int BIT = 64;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic rx8 = 1'b1, rdy8 = 1'b1, rx7 = 1'b1, rdy7 = 1'b1;
  logic [7:0] d8;
  logic [6:0] d7;
  logic v8, fe8, pe8, ov8, bz8, v7, fe7, pe7, ov7, bz7;
  logic hs8 = 1'b0, hs7 = 1'b0;
  logic [10:0] obs8[$], obs7[$];
  int checks = 0, errors = 0, dbl = 0;
  always #5 clk = ~clk;
  uart_rx_core #(.CLK_FREQ(7372800), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .busy(bz8));
  uart_rx_core #(.CLK_FREQ(7372800), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
    .frame_err(fe7), .parity_err(pe7), .overrun(ov7), .busy(bz7));
  // every accepted word is queued; a valid that survives its own handshake counts as a double pulse
  always @(negedge clk) begin
    if ((v8 && hs8) || (v7 && hs7)) dbl++;
    hs8 = v8 && rdy8;
    hs7 = v7 && rdy7;
    if (hs8) obs8.push_back({1'b0, d8, fe8, pe8});
    if (hs7) obs7.push_back({2'b0, d7, fe7, pe7});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic line(input int sel, input logic b, input int n);
    if (sel != 0) rx7 = b;
    else rx8 = b;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input int sel, input logic [8:0] data, input int nb, input bit has_par,
                      input logic pbit, input logic stop, input int gap);
    line(sel, 1'b0, BIT);
    for (int i = 0; i < nb; i++) line(sel, data[i], BIT);
    if (has_par) line(sel, pbit, BIT);
    line(sel, stop, BIT);
    line(sel, 1'b1, gap);
  endtask
  task automatic expect_frame(input string name, input int sel, input logic [8:0] ed,
                              input logic efe, input logic epe);
    logic [10:0] r;
    int n = 0;
    while (n < 4 * BIT && (sel != 0 ? obs7.size() : obs8.size()) == 0) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_arrived"}, 32'((sel != 0 ? obs7.size() : obs8.size()) != 0), 1);
    if ((sel != 0 ? obs7.size() : obs8.size()) != 0) begin
      if (sel != 0) r = obs7.pop_front();
      else r = obs8.pop_front();
      chk({name, "_data"}, r[10:2], ed);
      chk({name, "_frame_err"}, r[1], efe);
      chk({name, "_parity_err"}, r[0], epe);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t tbl[6];
    logic [7:0] rd;
    logic [6:0] r7;
    logic rs, pb;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    tbl[2] = '{8'h11, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    tbl[5] = '{8'h80, 1'b1, 8'h80, 1'b0};
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", v8, 0);
    chk("rst_busy", bz8, 0);
    chk("rst_data", d8, 0);
    chk("rst_overrun", ov8, 0);
    chk("rst_frame_err", fe8, 0);
    chk("rst_parity_err", pe8, 0);
    chk("rst_valid7", v7, 0);
    chk("rst_busy7", bz7, 0);
    chk("rst_overrun7", ov7, 0);
    rst = 1'b0;
    line(0, 1'b1, 8);
    for (int i = 0; i < 6; i++) begin
      send(0, {1'b0, tbl[i].data}, 8, 1'b0, 1'b0, tbl[i].stop, 16);
      expect_frame("table", 0, {1'b0, tbl[i].exp_data}, tbl[i].exp_fe, 1'b0);
    end
    chk("idle_busy", bz8, 0);
    send(1, 9'h41, 7, 1'b1, 1'b1, 1'b1, 16);
    expect_frame("even_bad", 1, 9'h41, 1'b0, 1'b1);
    send(1, 9'h41, 7, 1'b1, 1'b0, 1'b1, 16);
    expect_frame("even_good", 1, 9'h41, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom);
      rs = $urandom_range(0, 5) != 0;
      send(0, {1'b0, rd}, 8, 1'b0, 1'b0, rs, $urandom_range(4, 40));
      expect_frame("rand8", 0, {1'b0, rd}, ~rs, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      r7 = 7'($urandom);
      pb = 1'($urandom_range(0, 1));
      send(1, {2'b0, r7}, 7, 1'b1, pb, 1'b1, $urandom_range(4, 40));
      expect_frame("rand7", 1, {2'b0, r7}, 1'b0, 1'(($countones(r7) + int'(pb)) % 2));
    end
    rdy8 = 1'b0;
    send(0, 9'h12, 8, 1'b0, 1'b0, 1'b1, 16);
    send(0, 9'h34, 8, 1'b0, 1'b0, 1'b1, 16);
    chk("ovr_valid", v8, 1);
    chk("ovr_data", d8, 8'h12);
    chk("ovr_flag", ov8, 1);
    chk("ovr_no_handshake", obs8.size(), 0);
    rdy8 = 1'b1;
    chk("ovr_flag_held", ov8, 1);
    @(posedge clk);
    #1;
    chk("ovr_cleared", ov8, 0);
    chk("ovr_valid_fell", v8, 0);
    expect_frame("ovr_word", 0, 9'h12, 1'b0, 1'b0);
    line(0, 1'b0, 20);
    chk("glitch_busy", bz8, 1);
    line(0, 1'b1, 100);
    chk("glitch_idle", bz8, 0);
    chk("glitch_no_word", obs8.size(), 0);
    chk("glitch_no_valid", v8, 0);
`ifdef UART_RX_MAJORITY_EN
    line(0, 1'b0, BIT);
    line(0, 1'b0, 30);
    line(0, 1'b1, 4);
    line(0, 1'b0, 30);
    for (int i = 1; i < 8; i++) line(0, 1'b0, BIT);
    line(0, 1'b1, BIT);
    line(0, 1'b1, 16);
    expect_frame("spike", 0, 9'h00, 1'b0, 1'b0);
`endif
    line(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) line(0, 1'b1, BIT);
    line(0, 1'b1, 32);
    chk("mid_busy", bz8, 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_busy", bz8, 0);
    chk("mid_rst_valid", v8, 0);
    rst = 1'b0;
    line(0, 1'b1, 2 * BIT);
    chk("mid_no_word", obs8.size(), 0);
    send(0, 9'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
    expect_frame("after_rst", 0, 9'h5A, 1'b0, 1'b0);
    chk("single_cycle_valid", dbl, 0);
    chk("no_stray7", obs7.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
